// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset microsequencer: state codes, ALU functions and datapath mux selects.
// Pure declarations; no latency or backpressure of its own.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH0  = 4'd1,
        S_FETCH1  = 4'd2,
        S_FETCH2  = 4'd3,
        S_DECODE  = 4'd4,
        S_DP_EXEC = 4'd5,
        S_LS_ADDR = 4'd6,
        S_LD_MEM  = 4'd7,
        S_LD_WB   = 4'd8,
        S_ST_DATA = 4'd9,
        S_ST_MEM  = 4'd10,
        S_BL_LINK = 4'd11,
        S_BR_EXEC = 4'd12,
        S_FAULT   = 4'd15
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    localparam logic [1:0] MA_RN    = 2'b00;
    localparam logic [1:0] MA_PC    = 2'b01;
    localparam logic [1:0] MA_MDR   = 2'b10;
    localparam logic [1:0] MA_ZERO  = 2'b11;

    localparam logic [1:0] MB_SHIFT = 2'b00;
    localparam logic [1:0] MB_FOUR  = 2'b01;
    localparam logic [1:0] MB_ZERO  = 2'b10;

    localparam logic [1:0] RD_IR    = 2'b00;
    localparam logic [1:0] RD_LR    = 2'b01;
    localparam logic [1:0] RD_PC    = 2'b10;

    // States that hold a memory request open until MOC arrives.
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH1) || (s == S_LD_MEM) || (s == S_ST_MEM);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access waits for MOC; pulses timeout on the last allowed cycle without MOC.
// Combinational timeout from registered count; MOC on the limit cycle suppresses the timeout.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic CLK,
    input  logic CLR,
    input  logic clear,
    input  logic tick,
    input  logic moc,
    output logic timeout
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && !moc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = tick && !moc && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/arm_control_unit.sv
// Multi-cycle fetch/decode/execute microsequencer driving datapath load enables, mux selects and memory control.
// Moore outputs from registered state; memory states stall on MOC, falling into sticky FAULT after WAIT_LIMIT cycles.
module arm_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] IR,
    input  logic        COND,
    input  logic        MOC,
    output logic        IR_LE,
    output logic        MAR_LE,
    output logic        MDR_LE,
    output logic        SR_LE,
    output logic        RF_LE,
    output logic        PC_LE,
    output logic [1:0]  MA_SEL,
    output logic [1:0]  MB_SEL,
    output logic        MDR_SEL,
    output logic [1:0]  RD_SEL,
    output logic [3:0]  ALU_OP,
    output logic        MEM_EN,
    output logic        MEM_RW,
    output logic        FAULT,
    output logic [3:0]  STATE
);

    state_e state_q;
    state_e state_d;
    logic   in_wait;
    logic   wait_clear;
    logic   timeout;
    logic   dp_test_op;
    logic   unused_ir;

    assign unused_ir  = ^{IR[31:28], IR[19:0]};
    assign in_wait    = is_wait_state(state_q);
    assign wait_clear = is_wait_state(state_d) && (state_d != state_q);
    // TST/TEQ/CMP/CMN only update flags.
    assign dp_test_op = (IR[24:23] == 2'b10);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .CLK     (CLK),
        .CLR     (CLR),
        .clear   (wait_clear),
        .tick    (in_wait),
        .moc     (MOC),
        .timeout (timeout)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_FETCH0;
            S_FETCH0:  state_d = S_FETCH1;
            S_FETCH1:  state_d = MOC ? S_FETCH2 : (timeout ? S_FAULT : S_FETCH1);
            S_FETCH2:  state_d = S_DECODE;
            S_DECODE: begin
                if (!COND) begin
                    state_d = S_FETCH0;
                end else if (IR[27:26] == 2'b00) begin
                    state_d = S_DP_EXEC;
                end else if (IR[27:26] == 2'b01) begin
                    state_d = S_LS_ADDR;
                end else if (IR[27:25] == 3'b101) begin
                    state_d = IR[24] ? S_BL_LINK : S_BR_EXEC;
                end else begin
                    state_d = S_FETCH0;
                end
            end
            S_DP_EXEC: state_d = S_FETCH0;
            S_LS_ADDR: state_d = IR[20] ? S_LD_MEM : S_ST_DATA;
            S_LD_MEM:  state_d = MOC ? S_LD_WB : (timeout ? S_FAULT : S_LD_MEM);
            S_LD_WB:   state_d = S_FETCH0;
            S_ST_DATA: state_d = S_ST_MEM;
            S_ST_MEM:  state_d = MOC ? S_FETCH0 : (timeout ? S_FAULT : S_ST_MEM);
            S_BL_LINK: state_d = S_BR_EXEC;
            S_BR_EXEC: state_d = S_FETCH0;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_FETCH0;
        endcase
    end

    always_comb begin
        IR_LE   = 1'b0;
        MAR_LE  = 1'b0;
        MDR_LE  = 1'b0;
        SR_LE   = 1'b0;
        RF_LE   = 1'b0;
        PC_LE   = 1'b0;
        MA_SEL  = MA_RN;
        MB_SEL  = MB_SHIFT;
        MDR_SEL = 1'b0;
        RD_SEL  = RD_IR;
        ALU_OP  = ALU_ADD;
        MEM_EN  = 1'b0;
        MEM_RW  = 1'b0;
        FAULT   = 1'b0;
        case (state_q)
            S_FETCH0: begin
                MA_SEL = MA_PC;
                MB_SEL = MB_ZERO;
                MAR_LE = 1'b1;
            end
            S_FETCH1, S_LD_MEM: begin
                MEM_EN = 1'b1;
                MEM_RW = 1'b1;
                MDR_LE = 1'b1;
            end
            S_FETCH2: begin
                IR_LE  = 1'b1;
                MA_SEL = MA_PC;
                MB_SEL = MB_FOUR;
                RD_SEL = RD_PC;
                PC_LE  = 1'b1;
            end
            S_DP_EXEC: begin
                ALU_OP = IR[24:21];
                RF_LE  = !dp_test_op;
                SR_LE  = IR[20] || dp_test_op;
            end
            S_LS_ADDR: begin
                ALU_OP = IR[23] ? ALU_ADD : ALU_SUB;
                MAR_LE = 1'b1;
            end
            S_LD_WB: begin
                MA_SEL = MA_MDR;
                MB_SEL = MB_ZERO;
                RF_LE  = 1'b1;
            end
            S_ST_DATA: begin
                MDR_SEL = 1'b1;
                MA_SEL  = MA_ZERO;
                MDR_LE  = 1'b1;
            end
            S_ST_MEM:  MEM_EN = 1'b1;
            S_BL_LINK: begin
                MA_SEL = MA_PC;
                MB_SEL = MB_ZERO;
                RD_SEL = RD_LR;
                RF_LE  = 1'b1;
            end
            S_BR_EXEC: begin
                MA_SEL = MA_PC;
                RD_SEL = RD_PC;
                PC_LE  = 1'b1;
            end
            S_FAULT:   FAULT = 1'b1;
            default:   ;
        endcase
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench: builds the expected state trace per instruction from the instruction-class rules and
// checks STATE plus every output each cycle, with literal pins on latencies and key control pulses.
module tb_arm_control_unit;

    localparam int WL = 16;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        COND = 1'b0;
    logic        MOC = 1'b0;
    logic        IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, PC_LE;
    logic [1:0]  MA_SEL, MB_SEL, RD_SEL;
    logic        MDR_SEL, MEM_EN, MEM_RW, FAULT;
    logic [3:0]  ALU_OP, STATE;
    logic [19:0] dut_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tr_st[$];
    bit tr_moc[$];
    int ld_cnt, st_cnt, rfsr_cnt;
    logic [3:0] dp_alu;
    logic dp_rf, dp_sr, bl_rf, br_pc;
    logic [1:0] bl_rd, br_rd;

    arm_control_unit #(.WAIT_LIMIT(WL)) dut (
        .CLK(CLK), .CLR(CLR), .IR(IR), .COND(COND), .MOC(MOC),
        .IR_LE(IR_LE), .MAR_LE(MAR_LE), .MDR_LE(MDR_LE), .SR_LE(SR_LE), .RF_LE(RF_LE), .PC_LE(PC_LE),
        .MA_SEL(MA_SEL), .MB_SEL(MB_SEL), .MDR_SEL(MDR_SEL), .RD_SEL(RD_SEL), .ALU_OP(ALU_OP),
        .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    assign dut_o = {IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, PC_LE, MA_SEL, MB_SEL, MDR_SEL, RD_SEL,
                    ALU_OP, MEM_EN, MEM_RW, FAULT};

    // Expected control word for a state number, straight from the per-state action list.
    function automatic logic [19:0] exp_out(int st, logic [31:0] ir);
        logic ir_le, mar_le, mdr_le, sr_le, rf_le, pc_le, mdr_sel, mem_en, mem_rw, flt, cmp;
        logic [1:0] ma, mb, rd;
        logic [3:0] op;
        {ir_le, mar_le, mdr_le, sr_le, rf_le, pc_le, mdr_sel, mem_en, mem_rw, flt} = '0;
        ma = 2'd0; mb = 2'd0; rd = 2'd0; op = 4'b0100;
        cmp = (ir[24:23] == 2'b10);
        case (st)
            1:  begin ma = 2'd1; mb = 2'd2; mar_le = 1'b1; end
            2, 7: begin mem_en = 1'b1; mem_rw = 1'b1; mdr_le = 1'b1; end
            3:  begin ir_le = 1'b1; ma = 2'd1; mb = 2'd1; rd = 2'd2; pc_le = 1'b1; end
            5:  begin op = ir[24:21]; rf_le = !cmp; sr_le = ir[20] | cmp; end
            6:  begin op = ir[23] ? 4'b0100 : 4'b0010; mar_le = 1'b1; end
            8:  begin ma = 2'd2; mb = 2'd2; rf_le = 1'b1; end
            9:  begin mdr_sel = 1'b1; ma = 2'd3; mdr_le = 1'b1; end
            10: mem_en = 1'b1;
            11: begin ma = 2'd1; mb = 2'd2; rd = 2'd1; rf_le = 1'b1; end
            12: begin ma = 2'd1; rd = 2'd2; pc_le = 1'b1; end
            15: flt = 1'b1;
            default: ;
        endcase
        return {ir_le, mar_le, mdr_le, sr_le, rf_le, pc_le, ma, mb, mdr_sel, rd, op, mem_en, mem_rw, flt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A wait state lasting `dly` cycles without MOC; returns 1 if that exhausts the limit.
    function automatic bit add_wait(int st, int dly, bit idle);
        if (dly >= WL) begin
            repeat (WL) begin tr_st.push_back(st); tr_moc.push_back(1'b0); end
            repeat (3)  begin tr_st.push_back(15); tr_moc.push_back(idle); end
            return 1'b1;
        end
        repeat (dly) begin tr_st.push_back(st); tr_moc.push_back(1'b0); end
        tr_st.push_back(st); tr_moc.push_back(1'b1);
        return 1'b0;
    endfunction

    function automatic void add(int st, bit idle);
        tr_st.push_back(st);
        tr_moc.push_back(idle);
    endfunction

    function automatic void build(logic [31:0] ir, bit cond, int fdly, int mdly, bit idle);
        tr_st.delete();
        tr_moc.delete();
        add(1, idle);
        if (add_wait(2, fdly, idle)) return;
        add(3, idle);
        add(4, idle);
        if (!cond) return;
        if (ir[27:26] == 2'b00) begin
            add(5, idle);
        end else if (ir[27:26] == 2'b01) begin
            add(6, idle);
            if (ir[20]) begin
                if (!add_wait(7, mdly, idle)) add(8, idle);
            end else begin
                add(9, idle);
                void'(add_wait(10, mdly, idle));
            end
        end else if (ir[27:25] == 3'b101) begin
            if (ir[24]) add(11, idle);
            add(12, idle);
        end
    endfunction

    // Plays the trace (or its first n entries), checking the DUT on each cycle's falling edge.
    task automatic run(input logic [31:0] ir, input bit cond, input int fdly, input int mdly,
                       input bit idle, input int n);
        int lim;
        build(ir, cond, fdly, mdly, idle);
        lim = (n < 0) ? tr_st.size() : n;
        ld_cnt = 0; st_cnt = 0; rfsr_cnt = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge CLK);
            #1;
            if (i == 0) begin IR = ir; COND = cond; end
            MOC = tr_moc[i];
            @(negedge CLK);
            chk("state", {28'd0, STATE}, tr_st[i]);
            chk("outputs", {12'd0, dut_o}, {12'd0, exp_out(tr_st[i], IR)});
            if (STATE == 4'd7) ld_cnt++;
            if (STATE == 4'd10) st_cnt++;
            if (RF_LE || SR_LE) rfsr_cnt++;
            if (STATE == 4'd5) begin dp_alu = ALU_OP; dp_rf = RF_LE; dp_sr = SR_LE; end
            if (STATE == 4'd11) begin bl_rd = RD_SEL; bl_rf = RF_LE; end
            if (STATE == 4'd12) begin br_rd = RD_SEL; br_pc = PC_LE; end
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("reset_state", {28'd0, STATE}, 32'd0);
        chk("reset_outs", {12'd0, dut_o}, 32'h00020);
        CLR = 1'b1;

        run(32'hE0821003, 1'b1, 0, 0, 1'b1, -1);
        chk("add_len", tr_st.size(), 5);
        chk("add_alu", {28'd0, dp_alu}, 32'h4);
        chk("add_rf_sr", {30'd0, dp_rf, dp_sr}, 32'b10);

        run(32'h01530004, 1'b0, 0, 0, 1'b0, -1);
        chk("condfail_len", tr_st.size(), 4);
        chk("condfail_no_rf_sr", rfsr_cnt, 0);

        run(32'h01530004, 1'b1, 0, 0, 1'b0, -1);
        chk("cmp_alu", {28'd0, dp_alu}, 32'hA);
        chk("cmp_rf_sr", {30'd0, dp_rf, dp_sr}, 32'b01);

        run(32'hEB000002, 1'b1, 0, 0, 1'b0, -1);
        chk("bl_len", tr_st.size(), 6);
        chk("bl_link", {29'd0, bl_rf, bl_rd}, 32'b101);
        chk("br_exec", {29'd0, br_pc, br_rd}, 32'b110);

        run(32'hEA000001, 1'b1, 0, 0, 1'b1, -1);
        run(32'hEF000000, 1'b1, 0, 0, 1'b0, -1);

        run(32'hE5912000, 1'b1, 0, 3, 1'b0, -1);
        chk("ldr_len", tr_st.size(), 10);
        chk("ldr_mem_cycles", ld_cnt, 4);

        run(32'hE5912000, 1'b1, 0, WL - 1, 1'b1, -1);
        chk("ldr_limit_moc_wins", ld_cnt, WL);

        run(32'hE5012000, 1'b1, 1, 2, 1'b0, -1);
        chk("str_len", tr_st.size(), 10);

        run(32'hE5912000, 1'b1, 0, 10, 1'b0, 7);
        #1 CLR = 1'b0;
        #1;
        chk("abort_state", {28'd0, STATE}, 32'd0);
        chk("abort_outs", {12'd0, dut_o}, 32'h00020);
        @(posedge CLK);
        #1;
        chk("abort_held", {28'd0, STATE}, 32'd0);
        MOC = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;

        run(32'hE0821003, 1'b1, 0, 0, 1'b0, -1);

        run(32'hE5812000, 1'b1, 0, 100, 1'b1, -1);
        chk("str_fault_cycles", st_cnt, 16);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1 MOC = i[0];
            @(negedge CLK);
            chk("fault_sticky", {30'd0, STATE == 4'd15, FAULT}, 32'b11);
        end
        #1 CLR = 1'b0;
        #1;
        chk("fault_clr", {28'd0, STATE, FAULT}, 32'd0);
        MOC = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        run(32'hE0821003, 1'b1, 0, 0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
